// File: rtl/sram_fifo_ctrl.sv
// FIFO controller over an external synchronous SRAM with one-cycle registered read data.
// Optional almost-full flag enabled by defining SRAM_FIFO_CTRL_AFULL_EN.
module sram_fifo_ctrl #(
  parameter int unsigned AW       = 8,
  parameter int unsigned DW       = 32,
  parameter int unsigned AFULL_TH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  // push side
  input  logic          wvalid_i,
  output logic          wready_o,
  input  logic [DW-1:0] wdata_i,
  // pop side
  output logic          rvalid_o,
  input  logic          rready_i,
  output logic [DW-1:0] rdata_o,
  // status
  output logic [AW:0]   cnt_o,
  output logic          afull_o,
  // SRAM ports
  output logic          sram_wren_o,
  output logic [AW-1:0] sram_waddr_o,
  output logic [DW-1:0] sram_wdata_o,
  output logic [AW-1:0] sram_raddr_o,
  input  logic [DW-1:0] sram_rdata_i
);

  localparam logic [AW:0] Depth     = {1'b1, {AW{1'b0}}};
  localparam bit          AfullThOk = (AFULL_TH >= 1) && (AFULL_TH < (2 ** AW));

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          rvalid_q, rvalid_d;
  logic          push, pop, collide;
  logic [AW-1:0] raddr;

  assign wready_o = (cnt_q != Depth);
  // Qualified by rst_n so the SRAM is never written while reset is held.
  assign push     = wvalid_i && wready_o && rst_n;
  assign pop      = rvalid_q && rready_i;

  always_comb begin
    raddr   = pop ? (rptr_q + AW'(1)) : rptr_q;
    wptr_d  = push ? (wptr_q + AW'(1)) : wptr_q;
    rptr_d  = raddr;
    cnt_d   = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    // Writing the address being read this edge: SRAM returns old data, so hold off one cycle.
    collide  = push && (wptr_q == raddr);
    rvalid_d = (cnt_d != '0) && !collide;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rvalid_o     = rvalid_q;
  assign rdata_o      = sram_rdata_i;
  assign cnt_o        = cnt_q;
  assign sram_wren_o  = push;
  assign sram_waddr_o = wptr_q;
  assign sram_wdata_o = wdata_i;
  assign sram_raddr_o = raddr;

`ifdef SRAM_FIFO_CTRL_AFULL_EN
  localparam logic [AW:0] AfullLvl = Depth - (AW+1)'(AFULL_TH);
  assign afull_o = (cnt_q >= AfullLvl);
`else
  assign afull_o = 1'b0;
`endif

  a_th_legal: assert property (@(posedge clk) AfullThOk);
  a_cnt_max:  assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= Depth);
  a_rv_cnt:   assert property (@(posedge clk) disable iff (!rst_n) rvalid_q |-> cnt_q != '0);

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl (AW=3, DW=8) with a behavioural registered-read SRAM.
module tb_sram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wvalid, wready, rvalid, rready, afull, wren;
  logic [7:0] wdata, rdata, sram_wdata, sram_rdata;
  logic [3:0] cnt;
  logic [2:0] waddr, raddr;
  logic [7:0] mem [8];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_fifo_ctrl #(.AW(3), .DW(8), .AFULL_TH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wvalid_i     (wvalid),
    .wready_o     (wready),
    .wdata_i      (wdata),
    .rvalid_o     (rvalid),
    .rready_i     (rready),
    .rdata_o      (rdata),
    .cnt_o        (cnt),
    .afull_o      (afull),
    .sram_wren_o  (wren),
    .sram_waddr_o (waddr),
    .sram_wdata_o (sram_wdata),
    .sram_raddr_o (raddr),
    .sram_rdata_i (sram_rdata)
  );

  // Registered read, old data on same-address write
  always @(posedge clk) begin
    if (wren) mem[waddr] <= sram_wdata;
    sram_rdata <= mem[raddr];
  end

  function automatic logic exp_afull(int c);
`ifdef SRAM_FIFO_CTRL_AFULL_EN
    return c >= 6;
`else
    return 1'b0;
`endif
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; wvalid = 1'b1; wdata = 8'hEE; rready = 1'b1;
    #3;
    total++; if (cnt !== 4'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", cnt); end
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%b exp=0", rvalid); end
    total++; if (wready !== 1'b1) begin bad++; $display("FAIL rst_wready got=%b exp=1", wready); end
    total++; if (wren !== 1'b0) begin bad++; $display("FAIL rst_wren got=%b exp=0", wren); end
    total++; if (afull !== 1'b0) begin bad++; $display("FAIL rst_afull got=%b exp=0", afull); end
    total++; if (raddr !== 3'd0) begin bad++; $display("FAIL rst_raddr got=%0d exp=0", raddr); end
    step;
    step;
    total++; if (cnt !== 4'd0) begin bad++; $display("FAIL rst_hold_cnt got=%0d exp=0", cnt); end
    wvalid = 1'b0; rready = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    wvalid = 1'b1; wdata = 8'hA5; rready = 1'b1;
    #1;
    total++; if (wren !== 1'b1 || waddr !== 3'd0) begin
      bad++; $display("FAIL single_wr got wren=%b waddr=%0d exp 1/0", wren, waddr); end
    step;  // E0
    wvalid = 1'b0;
    total++; if (cnt !== 4'd1 || rvalid !== 1'b0) begin
      bad++; $display("FAIL single_e0 got cnt=%0d rvalid=%b exp 1/0", cnt, rvalid); end
    step;  // E1
    total++; if (rvalid !== 1'b1 || rdata !== 8'hA5) begin
      bad++; $display("FAIL single_e1 got rvalid=%b rdata=%h exp 1/a5", rvalid, rdata); end
    step;  // E2: popped
    total++; if (cnt !== 4'd0 || rvalid !== 1'b0) begin
      bad++; $display("FAIL single_e2 got cnt=%0d rvalid=%b exp 0/0", cnt, rvalid); end
    rready = 1'b0;
  endtask

  task automatic test_fill_drain;
    rready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wvalid = 1'b1; wdata = 8'(i);
      step;
      total++; if (cnt !== 4'(i + 1) || afull !== exp_afull(i + 1)) begin
        bad++; $display("FAIL fill_cnt got cnt=%0d afull=%b exp %0d/%b", cnt, afull, i + 1,
                        exp_afull(i + 1)); end
    end
    wdata = 8'h99;
    #1;
    total++; if (wready !== 1'b0 || wren !== 1'b0) begin
      bad++; $display("FAIL full_block got wready=%b wren=%b exp 0/0", wready, wren); end
    step;
    total++; if (cnt !== 4'd8) begin bad++; $display("FAIL full_cnt got=%0d exp=8", cnt); end
    wvalid = 1'b0; rready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      total++; if (rvalid !== 1'b1 || rdata !== 8'(i)) begin
        bad++; $display("FAIL drain_data got rvalid=%b rdata=%h exp 1/%h", rvalid, rdata, 8'(i)); end
      total++; if (cnt !== 4'(8 - i) || afull !== exp_afull(8 - i)) begin
        bad++; $display("FAIL drain_cnt got cnt=%0d afull=%b exp %0d/%b", cnt, afull, 8 - i,
                        exp_afull(8 - i)); end
      step;
      if (i == 0) begin
        total++; if (wready !== 1'b1) begin
          bad++; $display("FAIL unfull_wready got=%b exp=1", wready); end
      end
    end
    rready = 1'b0;
    total++; if (cnt !== 4'd0 || rvalid !== 1'b0) begin
      bad++; $display("FAIL drain_end got cnt=%0d rvalid=%b exp 0/0", cnt, rvalid); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] q[$];
    rready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wvalid = 1'b1; wdata = 8'h10 + 8'(i); q.push_back(wdata);
      step;
    end
    for (int k = 0; k < 20; k++) begin
      wvalid = 1'b1; wdata = 8'h20 + 8'(k); rready = 1'b1;
      #1;
      total++; if (rvalid !== 1'b1 || cnt !== 4'd4 || rdata !== q[0]) begin
        bad++; $display("FAIL stream got rvalid=%b cnt=%0d rdata=%h exp 1/4/%h", rvalid, cnt,
                        rdata, q[0]); end
      void'(q.pop_front());
      q.push_back(wdata);
      step;
    end
    wvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (rvalid !== 1'b1 || rdata !== q[0]) begin
        bad++; $display("FAIL stream_tail got rvalid=%b rdata=%h exp 1/%h", rvalid, rdata, q[0]); end
      void'(q.pop_front());
      step;
    end
    rready = 1'b0;
    total++; if (cnt !== 4'd0 || rvalid !== 1'b0) begin
      bad++; $display("FAIL stream_end got cnt=%0d rvalid=%b exp 0/0", cnt, rvalid); end
  endtask

  task automatic test_collision;
    wvalid = 1'b1; wdata = 8'h55; rready = 1'b0;
    step;
    wvalid = 1'b0;
    step;
    total++; if (rvalid !== 1'b1 || rdata !== 8'h55 || cnt !== 4'd1) begin
      bad++; $display("FAIL coll_pre got rvalid=%b rdata=%h cnt=%0d exp 1/55/1", rvalid, rdata,
                      cnt); end
    wvalid = 1'b1; wdata = 8'h66; rready = 1'b1;
    step;
    wvalid = 1'b0; rready = 1'b0;
    total++; if (rvalid !== 1'b0 || cnt !== 4'd1) begin
      bad++; $display("FAIL coll_gap got rvalid=%b cnt=%0d exp 0/1", rvalid, cnt); end
    step;
    total++; if (rvalid !== 1'b1 || rdata !== 8'h66) begin
      bad++; $display("FAIL coll_after got rvalid=%b rdata=%h exp 1/66", rvalid, rdata); end
    rready = 1'b1;
    step;
    rready = 1'b0;
    total++; if (cnt !== 4'd0) begin bad++; $display("FAIL coll_end got cnt=%0d exp=0", cnt); end
  endtask

  task automatic test_reset_mid;
    rready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wvalid = 1'b1; wdata = 8'h30 + 8'(i);
      step;
    end
    wvalid = 1'b0;
    total++; if (cnt !== 4'd5 || rvalid !== 1'b1) begin
      bad++; $display("FAIL mid_pre got cnt=%0d rvalid=%b exp 5/1", cnt, rvalid); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (cnt !== 4'd0 || rvalid !== 1'b0 || wready !== 1'b1) begin
      bad++; $display("FAIL mid_rst got cnt=%0d rvalid=%b wready=%b exp 0/0/1", cnt, rvalid,
                      wready); end
    step;
    rst_n = 1'b1;
    wvalid = 1'b1; wdata = 8'h77;
    step;
    wvalid = 1'b0;
    total++; if (cnt !== 4'd1 || rvalid !== 1'b0) begin
      bad++; $display("FAIL post_push got cnt=%0d rvalid=%b exp 1/0", cnt, rvalid); end
    step;
    total++; if (rvalid !== 1'b1 || rdata !== 8'h77) begin
      bad++; $display("FAIL post_data got rvalid=%b rdata=%h exp 1/77", rvalid, rdata); end
    rready = 1'b1;
    step;
    rready = 1'b0;
    total++; if (cnt !== 4'd0 || rvalid !== 1'b0) begin
      bad++; $display("FAIL post_end got cnt=%0d rvalid=%b exp 0/0", cnt, rvalid); end
  endtask

  initial begin
    rst_n = 1'b0; wvalid = 1'b0; rready = 1'b0; wdata = '0;
    @(posedge clk);
    #1;
    test_reset;
    test_single;
    test_fill_drain;
    test_back_to_back;
    test_collision;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_fifo_ctrl.md
SRAM_FIFO_CTRL -- requirements
Module: sram_fifo_ctrl

Interface
REQ-001 Parameter AW, default 8: SRAM address width; FIFO depth DEPTH = 2**AW entries.
REQ-002 Parameter DW, default 32: data width.
REQ-003 Parameter AFULL_TH, default 4: almost-full margin; legal range 1..DEPTH-1.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 wvalid_i  input  1 / wready_o  output  1 / wdata_i  input  DW  push handshake; push = wvalid_i && wready_o.
REQ-007 rvalid_o  output  1 / rready_i  input  1 / rdata_o  output  DW  pop handshake; pop = rvalid_o && rready_i.
REQ-008 cnt_o  output  AW+1  entries held, 0..DEPTH.
REQ-009 afull_o  output  1  almost-full flag.
REQ-010 sram_wren_o  output  1 / sram_waddr_o  output  AW / sram_wdata_o  output  DW  SRAM write port.
REQ-011 sram_raddr_o  output  AW / sram_rdata_i  input  DW  SRAM read port; sram_rdata_i is registered, one-cycle latency, returns old data on same-address read/write in one cycle.

Function
REQ-012 State: wptr, rptr (AW bits each, wrap DEPTH-1 -> 0 naturally), cnt (AW+1 bits), rvalid register.
REQ-013 wready_o = (cnt != DEPTH), combinational from registered cnt; no dependence on rready_i.
REQ-014 sram_wren_o = push; sram_waddr_o = wptr; sram_wdata_o = wdata_i; combinational.
REQ-015 sram_raddr_o = pop ? rptr+1 : rptr (mod DEPTH); held stable while no pop so sram_rdata_i keeps the head word.
REQ-016 rdata_o = sram_rdata_i directly; meaningful only while rvalid_o = 1.
REQ-017 On push: wptr increments; on pop: rptr increments; cnt_next = cnt + push - pop; simultaneous push and pop leaves cnt unchanged.
REQ-018 rvalid next = (cnt_next != 0) && !(sram_wren_o && sram_waddr_o == sram_raddr_o) (collision: head word not yet readable).
REQ-019 Latency: word pushed into empty FIFO at edge E0 -> rvalid_o = 1 after edge E1 with that word on rdata_o.
REQ-020 Back-to-back pops sustain one word per cycle when next entry was written at an earlier edge; when next entry is written on the same edge as the pop, rvalid_o drops for exactly one cycle.
REQ-021 Full (cnt = DEPTH): wready_o = 0; pop in that cycle makes wready_o = 1 next cycle; no push accepted while full.
REQ-022 Empty (cnt = 0): rvalid_o = 0; rready_i ignored.
REQ-023 cnt_o = cnt; never exceeds DEPTH, never underflows.
REQ-024 rvalid_o, once 1, stays 1 with stable rdata_o until pop.

Reset
REQ-025 rst_n low asynchronously forces wptr = 0, rptr = 0, cnt = 0, rvalid_o = 0; hence wready_o = 1, cnt_o = 0, afull_o = 0, sram_wren_o = 0 (wvalid_i is ignored while reset asserted), sram_raddr_o = 0.
REQ-026 Reset mid-operation discards all stored words; SRAM contents are not cleared and are never exposed as valid.
REQ-027 Release of rst_n takes effect on the next rising edge; first push accepted that edge.

Configuration
REQ-028 Macro SRAM_FIFO_CTRL_AFULL_EN defined: afull_o = (cnt >= DEPTH - AFULL_TH), combinational from registered cnt.
REQ-029 Macro undefined: afull_o tied 0, no comparator logic; all other behaviour identical.

Verification
REQ-030 AW=3: reset, push 0xA5 at E0, rready_i=1 -> rvalid_o=1 after E1, rdata_o=0xA5, popped at E2 edge, cnt_o back to 0.
REQ-031 AW=3: push 8 words 0..7 with rready_i=0 -> cnt_o=8, wready_o=0; 9th wvalid_i not accepted; drain -> data 0..7 in order, 8 consecutive pops.
REQ-032 AW=3: hold cnt 4, push and pop every cycle for 20 cycles -> cnt_o constant 4, rvalid_o constant 1, output order matches input order across pointer wrap.
REQ-033 AW=3: cnt 1, pop and push same cycle -> rvalid_o = 0 for one cycle, then new word valid.
REQ-034 SRAM_FIFO_CTRL_AFULL_EN defined, AW=3, AFULL_TH=2: afull_o rises when cnt_o reaches 6, falls at 5; undefined: afull_o = 0 throughout.
REQ-035 Assert rst_n low mid-stream with cnt 5 -> immediately cnt_o=0, rvalid_o=0, wready_o=1; post-reset traffic unaffected by stale data.
